// File: rtl/buffer_window_ctrl_pkg.sv
// Shared types and helpers for the column-buffer window controller.
// Optional stall statistics are enabled with BUFFER_WINDOW_CTRL_STATS_EN.
package buffer_ctrl_pkg;

    localparam int STATS_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic int addr_w(input int columns);
        return $clog2(columns);
    endfunction

endpackage

// File: rtl/buffer_window_ctrl_if.sv
// Producer/consumer handshakes and buffer address bus of the controller.
// master = controller side, slave = buffer/streamer/feeder side.
interface buffer_window_ctrl_if
    import buffer_ctrl_pkg::*;
#(
    parameter int COLUMNS   = 32,
    parameter int PAR_WRITE = 4,
    parameter int PAR_READ  = 4
);
    localparam int AW = addr_w(COLUMNS);

    logic                      start;
    logic                      in_valid;
    logic                      in_last;
    logic                      in_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic                      done;
    logic                      buf_wen;
    logic [PAR_WRITE*AW-1:0]   buf_waddr;
    logic [PAR_READ*AW-1:0]    buf_raddr;
    logic [AW:0]               occupancy;

    modport master (
        input  start,
        input  in_valid,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output done,
        output buf_wen,
        output buf_waddr,
        output buf_raddr,
        output occupancy
    );

    modport slave (
        output start,
        output in_valid,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  done,
        input  buf_wen,
        input  buf_waddr,
        input  buf_raddr,
        input  occupancy
    );

endinterface

// File: rtl/buffer_window_ctrl_lane_addr_gen.sv
// Expands a base pointer into LANES consecutive addresses.
// Wrap-around is the natural AW-bit truncation of base + lane.
module buffer_lane_addr_gen #(
    parameter int LANES = 4,
    parameter int AW    = 5
) (
    input  logic [AW-1:0]       i_base,
    output logic [LANES*AW-1:0] o_addr
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign o_addr[l*AW +: AW] = i_base + AW'(l);
    end

endmodule

// File: rtl/buffer_window_ctrl.sv
// Circular-queue sequencer for the multi-port column buffer.
// Define BUFFER_WINDOW_CTRL_STATS_EN to add saturating stall counters.
module buffer_window_ctrl
    import buffer_ctrl_pkg::*;
#(
    parameter int COLUMNS   = 32,
    parameter int PAR_WRITE = 4,
    parameter int PAR_READ  = 4,
    parameter int STRIDE    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    buffer_window_ctrl_if.master bus
`ifdef BUFFER_WINDOW_CTRL_STATS_EN
    ,
    output logic [STATS_W-1:0]   stall_full_cnt,
    output logic [STATS_W-1:0]   stall_empty_cnt
`endif
);

    localparam int AW = addr_w(COLUMNS);

    localparam logic [AW:0]   C_COLS = (AW+1)'(COLUMNS);
    localparam logic [AW:0]   C_PW   = (AW+1)'(PAR_WRITE);
    localparam logic [AW:0]   C_PR   = (AW+1)'(PAR_READ);
    localparam logic [AW:0]   C_ST   = (AW+1)'(STRIDE);
    localparam logic [AW-1:0] P_PW   = AW'(PAR_WRITE);
    localparam logic [AW-1:0] P_ST   = AW'(STRIDE);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;
    logic [AW-1:0]          w_wr_nxt;
    logic [AW-1:0]          w_rd_nxt;
    logic [AW:0]            w_count_nxt;

    logic                   w_in_ready;
    logic                   w_out_valid;
    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic                   w_clear;
    logic [PAR_WRITE*AW-1:0] w_waddr;
    logic [PAR_READ*AW-1:0]  w_raddr;

    // Full check uses registered count only; same-cycle reads free nothing.
    assign w_in_ready  = (r_state == RUN) && ((C_COLS - r_count) >= C_PW);
    assign w_out_valid = ((r_state == RUN) || (r_state == DRAIN))
                         && (r_count >= C_PR);
    assign w_wr_acc    = bus.in_valid && w_in_ready;
    assign w_rd_acc    = w_out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_wr_acc && bus.in_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if ((r_count < C_PR) && !w_rd_acc) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_clear     = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
                w_clear     = 1'b1;
            end
        endcase
    end

    // Tail entries below one window are dropped by the clear on DONE.
    always_comb begin
        w_wr_nxt    = r_wr_ptr;
        w_rd_nxt    = r_rd_ptr;
        w_count_nxt = r_count;
        if (w_clear) begin
            w_wr_nxt    = '0;
            w_rd_nxt    = '0;
            w_count_nxt = '0;
        end else begin
            if (w_wr_acc) begin
                w_wr_nxt = r_wr_ptr + P_PW;
            end
            if (w_rd_acc) begin
                w_rd_nxt = r_rd_ptr + P_ST;
            end
            w_count_nxt = r_count
                          + (w_wr_acc ? C_PW : '0)
                          - (w_rd_acc ? C_ST : '0);
        end
    end

    buffer_lane_addr_gen #(
        .LANES (PAR_WRITE),
        .AW    (AW)
    ) u_wr_lanes (
        .i_base (r_wr_ptr),
        .o_addr (w_waddr)
    );

    buffer_lane_addr_gen #(
        .LANES (PAR_READ),
        .AW    (AW)
    ) u_rd_lanes (
        .i_base (r_rd_ptr),
        .o_addr (w_raddr)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.done      = (r_state == DONE);
    assign bus.buf_wen   = w_wr_acc;
    assign bus.buf_waddr = w_waddr;
    assign bus.buf_raddr = w_raddr;
    assign bus.occupancy = r_count;

`ifdef BUFFER_WINDOW_CTRL_STATS_EN
    logic [STATS_W-1:0] r_stall_full;
    logic [STATS_W-1:0] r_stall_empty;
    logic               w_stats_clr;

    assign w_stats_clr = rst || (bus.start && (r_state == IDLE));

    always_ff @(posedge clk) begin
        if (w_stats_clr) begin
            r_stall_full  <= '0;
            r_stall_empty <= '0;
        end else if (r_state == RUN) begin
            if (bus.in_valid && !w_in_ready && (r_stall_full != '1)) begin
                r_stall_full <= r_stall_full + 1'b1;
            end
            if (bus.out_ready && !w_out_valid && (r_stall_empty != '1)) begin
                r_stall_empty <= r_stall_empty + 1'b1;
            end
        end
    end

    assign stall_full_cnt  = r_stall_full;
    assign stall_empty_cnt = r_stall_empty;
`endif

endmodule

// File: tb/tb_buffer_window_ctrl.sv
// Bench for buffer_window_ctrl: two instances (STRIDE 1 and 2) share stimulus
// and are checked each cycle against an arithmetic queue model.
module tb_buffer_window_ctrl;
    import buffer_ctrl_pkg::*;

    localparam int C  = 8;
    localparam int PW = 4;
    localparam int PR = 4;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b0;

    always #5 clk = ~clk;

    buffer_window_ctrl_if #(.COLUMNS(C), .PAR_WRITE(PW), .PAR_READ(PR)) b1 ();
    buffer_window_ctrl_if #(.COLUMNS(C), .PAR_WRITE(PW), .PAR_READ(PR)) b2 ();

    assign b1.start = start;
    assign b1.in_valid = in_valid;
    assign b1.in_last = in_last;
    assign b1.out_ready = out_ready;
    assign b2.start = start;
    assign b2.in_valid = in_valid;
    assign b2.in_last = in_last;
    assign b2.out_ready = out_ready;

`ifdef BUFFER_WINDOW_CTRL_STATS_EN
    logic [STATS_W-1:0] sf1, se1, sf2, se2;
`endif

    buffer_window_ctrl #(
        .COLUMNS(C), .PAR_WRITE(PW), .PAR_READ(PR), .STRIDE(1)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(b1)
`ifdef BUFFER_WINDOW_CTRL_STATS_EN
        ,
        .stall_full_cnt(sf1),
        .stall_empty_cnt(se1)
`endif
    );

    buffer_window_ctrl #(
        .COLUMNS(C), .PAR_WRITE(PW), .PAR_READ(PR), .STRIDE(2)
    ) dut2 (
        .clk(clk),
        .rst(rst),
        .bus(b2)
`ifdef BUFFER_WINDOW_CTRL_STATS_EN
        ,
        .stall_full_cnt(sf2),
        .stall_empty_cnt(se2)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    bit armed = 1'b0;
    bit collect = 1'b0;
    int q1[$];
    int q2[$];
    int d1 = 0;
    int d2 = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model phases: 0 idle, 1 streaming, 2 draining, 3 finished.
    int m_st[2]  = '{0, 0};
    int m_wr[2]  = '{0, 0};
    int m_rd[2]  = '{0, 0};
    int m_cnt[2] = '{0, 0};
    int strd[2]  = '{1, 2};

    function automatic bit e_inr(int k);
        return (m_st[k] == 1) && (C - m_cnt[k] >= PW);
    endfunction

    function automatic bit e_ov(int k);
        return (m_st[k] == 1 || m_st[k] == 2) && (m_cnt[k] >= PR);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit wa, ra;
            wa = in_valid && e_inr(k);
            ra = out_ready && e_ov(k);
            if (rst) begin
                m_st[k] = 0; m_wr[k] = 0; m_rd[k] = 0; m_cnt[k] = 0;
            end else if (m_st[k] == 3) begin
                m_st[k] = 0; m_wr[k] = 0; m_rd[k] = 0; m_cnt[k] = 0;
            end else begin
                if (m_st[k] == 0 && start) m_st[k] = 1;
                else if (m_st[k] == 1 && wa && in_last) m_st[k] = 2;
                else if (m_st[k] == 2 && m_cnt[k] < PR && !ra) m_st[k] = 3;
                if (wa) begin
                    m_wr[k] = (m_wr[k] + PW) % C;
                    m_cnt[k] += PW;
                end
                if (ra) begin
                    m_rd[k] = (m_rd[k] + strd[k]) % C;
                    m_cnt[k] -= strd[k];
                end
            end
        end
    end

    task automatic cmp(input int k, input logic inr, input logic ov,
                       input logic dn, input logic wen,
                       input logic [AW:0] occ,
                       input logic [PW*AW-1:0] wa,
                       input logic [PR*AW-1:0] ra);
        logic [PW*AW-1:0] ew;
        logic [PR*AW-1:0] er;
        for (int i = 0; i < PW; i++) ew[i*AW +: AW] = AW'((m_wr[k] + i) % C);
        for (int j = 0; j < PR; j++) er[j*AW +: AW] = AW'((m_rd[k] + j) % C);
        chk($sformatf("d%0d in_ready", k), 32'(inr), 32'(e_inr(k)));
        chk($sformatf("d%0d out_valid", k), 32'(ov), 32'(e_ov(k)));
        chk($sformatf("d%0d done", k), 32'(dn), 32'(m_st[k] == 3));
        chk($sformatf("d%0d buf_wen", k), 32'(wen),
            32'(in_valid && e_inr(k)));
        chk($sformatf("d%0d occupancy", k), 32'(occ), 32'(m_cnt[k]));
        chk($sformatf("d%0d buf_waddr", k), 32'(wa), 32'(ew));
        chk($sformatf("d%0d buf_raddr", k), 32'(ra), 32'(er));
    endtask

    always @(negedge clk) begin
        #2;
        if (armed) begin
            cmp(0, b1.in_ready, b1.out_valid, b1.done, b1.buf_wen,
                b1.occupancy, b1.buf_waddr, b1.buf_raddr);
            cmp(1, b2.in_ready, b2.out_valid, b2.done, b2.buf_wen,
                b2.occupancy, b2.buf_waddr, b2.buf_raddr);
        end
    end

    always @(negedge clk) begin
        #2;
        if (collect) begin
            if (b1.out_valid && b1.out_ready) q1.push_back(int'(b1.buf_raddr[AW-1:0]));
            if (b2.out_valid && b2.out_ready) q2.push_back(int'(b2.buf_raddr[AW-1:0]));
            if (b1.done) d1++;
            if (b2.done) d2++;
        end
    end

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) nc();
        armed = 1'b1;
        chk("rst in_ready", 32'(b1.in_ready), 0);
        chk("rst out_valid", 32'(b1.out_valid), 0);
        chk("rst done", 32'(b1.done), 0);
        chk("rst occupancy", 32'(b1.occupancy), 0);
        chk("rst waddr", 32'(b1.buf_waddr), 32'h688);
        chk("rst raddr", 32'(b1.buf_raddr), 32'h688);

        rst = 1'b0;
        start = 1'b1;
        nc();
        start = 1'b0;
        chk("t1 in_ready", 32'(b1.in_ready), 1);
        in_valid = 1'b1;
        #1;
        chk("t1 buf_wen", 32'(b1.buf_wen), 1);
        chk("t1 waddr", 32'(b1.buf_waddr), 32'h688);
        nc();
        chk("t1 out_valid", 32'(b1.out_valid), 1);
        chk("t1 occupancy", 32'(b1.occupancy), 4);
        chk("t1 raddr", 32'(b1.buf_raddr), 32'h688);

        nc();
        chk("t2 occupancy", 32'(b1.occupancy), 8);
        chk("t2 in_ready", 32'(b1.in_ready), 0);
        #1;
        chk("t2 buf_wen stall", 32'(b1.buf_wen), 0);
        nc();
        chk("t2 occupancy hold", 32'(b1.occupancy), 8);

        in_valid = 1'b0;
        out_ready = 1'b1;
        nc();
        chk("t3 occupancy", 32'(b1.occupancy), 7);
        chk("t3 raddr rd1", 32'(b1.buf_raddr), 32'h8D1);
        chk("t3 in_ready full", 32'(b1.in_ready), 0);
        repeat (3) nc();
        chk("t3 occupancy 4", 32'(b1.occupancy), 4);
        chk("t3 in_ready", 32'(b1.in_ready), 1);
        in_valid = 1'b1;
        #1;
        chk("t3 wrap waddr", 32'(b1.buf_waddr), 32'h688);
        chk("t3 wrap buf_wen", 32'(b1.buf_wen), 1);
        nc();
        chk("t4 occupancy", 32'(b1.occupancy), 7);

        in_valid = 1'b0;
        repeat (3) nc();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_last = 1'b1;
        nc();
        chk("t6 occupancy 8", 32'(b1.occupancy), 8);
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        repeat (2) nc();
        chk("t6 drain occupancy", 32'(b1.occupancy), 6);
        chk("t6 drain out_valid", 32'(b1.out_valid), 1);
        chk("t6 drain in_ready", 32'(b1.in_ready), 0);
        rst = 1'b1;
        nc();
        chk("t6 rst occupancy", 32'(b1.occupancy), 0);
        chk("t6 rst out_valid", 32'(b1.out_valid), 0);
        chk("t6 rst raddr", 32'(b1.buf_raddr), 32'h688);
`ifdef BUFFER_WINDOW_CTRL_STATS_EN
        chk("t6 stall_full", 32'(sf1), 0);
        chk("t6 stall_empty", 32'(se1), 0);
`endif
        rst = 1'b0;
        out_ready = 1'b0;
        nc();

        start = 1'b1;
        nc();
        start = 1'b0;
        collect = 1'b1;
        in_valid = 1'b1;
        nc();
        in_last = 1'b1;
        out_ready = 1'b1;
        nc();
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (12) nc();
        collect = 1'b0;
        chk("t5 s1 windows", 32'(q1.size()), 5);
        for (int i = 0; i < q1.size() && i < 5; i++)
            chk($sformatf("t5 s1 win%0d", i), 32'(q1[i]), 32'(i));
        chk("t5 s2 windows", 32'(q2.size()), 3);
        for (int i = 0; i < q2.size() && i < 3; i++)
            chk($sformatf("t5 s2 win%0d", i), 32'(q2[i]), 32'(2 * i));
        chk("t5 s1 done", 32'(d1), 1);
        chk("t5 s2 done", 32'(d2), 1);
        chk("t5 s1 occupancy", 32'(b1.occupancy), 0);
        chk("t5 s2 occupancy", 32'(b2.occupancy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/buffer_window_ctrl.md
# buffer_window_ctrl

Sequencing controller for the multi-port column buffer: it treats the buffer as a circular queue, generates `wen`, `waddr` and `raddr` for all write and read lanes, and exposes valid/ready handshakes to the producer (parallel writes) and the consumer (sliding windows). It sits between the input streamer and the PE array feeder. Data bypasses the controller: the producer drives the buffer's `din` directly, and the consumer samples `dout` directly.

## Interface

Parameters:

- COLUMNS, 32: buffer depth; must be a power of two.
- PAR_WRITE, 4: entries written per accepted beat; must satisfy PAR_WRITE ≤ COLUMNS.
- PAR_READ, 4: window width in entries; must satisfy PAR_READ ≤ COLUMNS.
- STRIDE, 1: entries retired per accepted window; 1 ≤ STRIDE ≤ PAR_READ.

Ports (AW = $clog2(COLUMNS)):

- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  begin a stream; only honoured in IDLE.
- in_valid  in  1  producer beat (PAR_WRITE entries) present.
- in_last  in  1  qualifies the final producer beat.
- in_ready  out  1  controller accepts the beat.
- out_valid  out  1  a full window is readable on buffer `dout`.
- out_ready  in  1  consumer takes the window.
- done  out  1  one-cycle pulse when the stream is finished.
- buf_wen  out  1  buffer write enable.
- buf_waddr  out  PAR_WRITE*AW  write-lane addresses.
- buf_raddr  out  PAR_READ*AW  read-lane addresses.
- occupancy  out  AW+1  valid entries currently held.

## Operation

- Registered state: wr_ptr (AW bits), rd_ptr (AW bits), count (AW+1 bits), fsm.
- Write lane i address = (wr_ptr + i) mod COLUMNS. Read lane j address = (rd_ptr + j) mod COLUMNS. Wrap uses natural AW-bit truncation.
- FSM states:
  - IDLE → RUN on start.
  - RUN → DRAIN when a beat with in_last is accepted.
  - DRAIN → DONE when count < PAR_READ and no window is being accepted.
  - DONE → IDLE unconditionally. On entering IDLE, pointers and count are cleared.
- in_ready = (fsm == RUN) && (COLUMNS − count ≥ PAR_WRITE).
- buf_wen = in_valid && in_ready.
- out_valid = (fsm ∈ {RUN, DRAIN}) && (count ≥ PAR_READ).
- Write accept: wr_ptr += PAR_WRITE and count += PAR_WRITE.
- Window accept (out_valid && out_ready): rd_ptr += STRIDE and count −= STRIDE.
- Simultaneous write and window accept: count += PAR_WRITE − STRIDE in one update.
- The full check uses registered count only; space freed by a same-cycle read is not used.
- Tail entries (count < PAR_READ at drain end) are discarded; no partial window is ever presented.
- start outside IDLE is ignored. in_valid outside RUN is ignored.

## Timing

- All outputs are combinational from registers except buf_wen, which also depends on in_valid.
- Reset values: in_ready 0, out_valid 0, done 0, buf_wen 0, occupancy 0, buf_waddr lanes 0..PAR_WRITE−1, buf_raddr lanes 0..PAR_READ−1, fsm IDLE.
- Write-to-visible latency: entries written at edge N count toward out_valid from cycle N+1 onward.
- The earliest window appears one cycle after the accepting edge of the beat that brings count to ≥ PAR_READ.
- DONE is held exactly one cycle. A start in the DONE cycle is ignored.
- rst mid-stream: the next edge returns to IDLE with all state cleared. Buffer contents are not touched by the controller.

## Configuration

- `BUFFER_WINDOW_CTRL_STATS_EN` defined: adds two 16-bit saturating counters as output ports.
  - stall_full_cnt increments when in_valid && !in_ready in RUN.
  - stall_empty_cnt increments when out_ready && !out_valid in RUN.
  - Both clear on rst and on start.
- Undefined: the counters and their ports are absent. Core behaviour is identical either way.

## Structure

- Package buffer_ctrl_pkg holds:
  - the state typedef enum {IDLE, RUN, DRAIN, DONE};
  - STATS_W = 16;
  - the function addr_w(columns) returning $clog2.
- One sub-module, buffer_lane_addr_gen (parameters LANES, AW), expands a base pointer into a packed lane-address vector. It is instantiated twice: once for writes, once for reads.

## Test plan

Use COLUMNS=8, PAR_WRITE=4, PAR_READ=4, STRIDE=1 unless stated.

1. Reset, then start, then one beat → buf_waddr = {3,2,1,0}. Next cycle out_valid=1, buf_raddr = {3,2,1,0}, occupancy=4.
2. Two beats with out_ready=0 → occupancy=8, in_ready=0. A third in_valid is stalled; buf_wen stays 0.
3. Continuous streaming with wrap: occupancy=8, one window accepted → rd_ptr=1. After three more window accepts occupancy=4 and in_ready=1; the next beat writes {3,2,1,0} (wrapped).
4. Same-cycle write and read at occupancy=4 → occupancy=7 next cycle.
5. in_last on the second beat (occupancy 8), out_ready=1 held → windows at rd_ptr 0..4, then done pulses once with occupancy cleared to 0. With STRIDE=2 the windows are at rd_ptr 0, 2, 4, then done.
6. rst asserted in DRAIN with occupancy=6 → next cycle fsm=IDLE, out_valid=0, occupancy=0. With STATS_EN, both stall counters read 0.
